// File: rtl/divider_if.sv
// Operand/result bundle for the iterative 32-bit RV32M divider.
// The master issues operands and the load strobe; the slave returns busy and the result.
interface divider_if;
   logic [31:0] a;
   logic [31:0] b;
   logic        ud;
   logic        rm;
   logic        load;
   logic        busy;
   logic [31:0] out;

   modport master (
      output a, b, ud, rm, load,
      input  busy, out
   );

   modport slave (
      input  a, b, ud, rm, load,
      output busy, out
   );
endinterface

// File: rtl/divider.sv
// Restoring shift-subtract divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// A last-operand cache lets a repeated request (e.g. DIV then REM) return without recomputing.
module divider (
   input  logic     clk,
   input  logic     reset,
   divider_if.slave dif
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state, state_nxt;
   logic [5:0]  cnt, cnt_nxt;

   logic        valid;
   logic        cud;
   logic [31:0] ca, cb;

   logic        sa, sb, bz;
   logic [31:0] q, r, mb;

   logic signed [31:0] a_s, b_s;
   logic        a_neg, b_neg;
   logic        iload, last;
   logic [32:0] rp, diff;
   logic        ge;
   logic [31:0] r_step, q_step;

   // Conditional two's-complement negation, used for magnitudes and final sign fix-up.
   function automatic logic [31:0] cneg(input logic [31:0] x, input logic neg);
      return neg ? (~x + 32'd1) : x;
   endfunction

   assign a_s   = signed'(dif.a);
   assign b_s   = signed'(dif.b);
   assign a_neg = ~dif.ud & (a_s < 0);
   assign b_neg = ~dif.ud & (b_s < 0);

   assign iload = dif.load & (~valid | ({dif.ud, dif.a, dif.b} != {cud, ca, cb}));
   assign last  = (state == RUN) & (cnt == 6'd1) & ~iload;

   assign dif.busy = iload | (state == RUN);
   assign dif.out  = dif.rm ? r : q;

   // The dividend magnitude shifts out of q MSB first while quotient bits shift in.
   always_comb begin
      rp     = {r, q[31]};
      diff   = rp - {1'b0, mb};
      ge     = (rp >= {1'b0, mb});
      r_step = ge ? diff[31:0] : rp[31:0];
      q_step = {q[30:0], ge};
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (iload) begin
         state_nxt = RUN;
         cnt_nxt   = 6'd32;
      end else if (state == RUN) begin
         cnt_nxt = cnt - 6'd1;
         if (cnt == 6'd1)
            state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 6'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // A new load takes priority over any step in flight, aborting it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid <= 1'b0;
         cud   <= 1'b0;
         ca    <= 32'd0;
         cb    <= 32'd0;
         sa    <= 1'b0;
         sb    <= 1'b0;
         bz    <= 1'b0;
         q     <= 32'd0;
         r     <= 32'd0;
         mb    <= 32'd0;
      end else if (iload) begin
         valid <= 1'b1;
         cud   <= dif.ud;
         ca    <= dif.a;
         cb    <= dif.b;
         sa    <= a_neg;
         sb    <= b_neg;
         bz    <= (dif.b == 32'd0);
         q     <= cneg(dif.a, a_neg);
         r     <= 32'd0;
         mb    <= cneg(dif.b, b_neg);
      end else if (state == RUN) begin
         if (last) begin
            q <= cneg(q_step, (sa ^ sb) & ~bz);
            r <= cneg(r_step, sa);
         end else begin
            q <= q_step;
            r <= r_step;
         end
      end
   end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for the divider: stimulus queues expected results, a monitor
// pops and compares them at each completion or cache-hit load.
module tb_divider;

   logic clk;
   logic reset;
   int   tests;
   int   fails;

   typedef struct {
      logic [31:0] val;
      int          cyc;
      string       nm;
   } exp_t;

   exp_t sb_q[$];

   divider_if dif ();

   divider u_dut (
      .clk   (clk),
      .reset (reset),
      .dif   (dif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic start(input logic [31:0] a, input logic [31:0] b, input logic ud,
                        input logic rm, input logic [31:0] exp, input int cyc, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      dif.a    = a;
      dif.b    = b;
      dif.ud   = ud;
      dif.rm   = rm;
      dif.load = 1'b1;
      e.val = exp;
      e.cyc = cyc;
      e.nm  = nm;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      dif.load = 1'b0;
   endtask

   // Load without expecting a completion (the run is aborted later).
   task automatic load_only(input logic [31:0] a, input logic [31:0] b, input logic ud);
      @(posedge clk);
      #1;
      dif.a    = a;
      dif.b    = b;
      dif.ud   = ud;
      dif.load = 1'b1;
      @(posedge clk);
      #1;
      dif.load = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!dif.busy) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: busy still 1 after 200 cycles, required 0", nm);
      end
   endtask

   // Compute with rm=0 (quotient), then reload identical operands with rm=1 (cache hit).
   task automatic div_pair(input logic [31:0] a, input logic [31:0] b, input logic ud,
                           input logic [31:0] qe, input logic [31:0] re, input string nm);
      start(a, b, ud, 1'b0, qe, 33, {nm, "_q"});
      wait_idle(nm);
      start(a, b, ud, 1'b1, re, 0, {nm, "_r"});
      wait_idle(nm);
   endtask

   // Monitor: a busy 1->0 transition is a completion; load with busy low is a cache hit.
   initial begin
      int   bcnt;
      logic prev_busy;
      exp_t e;
      bcnt      = 0;
      prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            bcnt      = 0;
            prev_busy = 1'b0;
         end else begin
            if (dif.busy)
               bcnt++;
            if ((dif.load && !dif.busy) || (prev_busy && !dif.busy)) begin
               if (sb_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_output: out 0x%08h with empty scoreboard", dif.out);
               end else begin
                  e = sb_q.pop_front();
                  check(e.nm, dif.out, e.val);
                  tests++;
                  if (bcnt != e.cyc) begin
                     fails++;
                     $display("FAIL %s_cycles: busy for %0d cycles, required %0d", e.nm, bcnt, e.cyc);
                  end
               end
            end
            if (!dif.busy)
               bcnt = 0;
            prev_busy = dif.busy;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tests    = 0;
      fails    = 0;
      reset    = 1'b1;
      dif.a    = 32'd0;
      dif.b    = 32'd0;
      dif.ud   = 1'b0;
      dif.rm   = 1'b0;
      dif.load = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", {31'd0, dif.busy}, 32'd0);
      check("reset_out_q", dif.out, 32'd0);
      dif.rm = 1'b1;
      #1;
      check("reset_out_r", dif.out, 32'd0);
      dif.rm = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      div_pair(32'd100, 32'd7, 1'b1, 32'd14, 32'd2, "u100_7");
      div_pair(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, "ud_change");
      div_pair(32'hFFFFFFF9, 32'd2, 1'b0, 32'hFFFFFFFD, 32'hFFFFFFFF, "sm7_2");
      div_pair(32'd7, 32'hFFFFFFFE, 1'b0, 32'hFFFFFFFD, 32'd1, "s7_m2");
      div_pair(32'hFFFFFFF9, 32'd0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFF9, "sdiv0");
      div_pair(32'd12345, 32'd0, 1'b1, 32'hFFFFFFFF, 32'd12345, "udiv0");
      div_pair(32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 32'd0, "sovf");
      div_pair(32'hFFFFFFFF, 32'd3, 1'b1, 32'h55555555, 32'd0, "umax_3");

      // Abort: second load lands on the tenth edge after the first.
      load_only(32'd100, 32'd7, 1'b1);
      repeat (8) @(posedge clk);
      start(32'hFFFFFFFF, 32'd16, 1'b1, 1'b0, 32'h0FFFFFFF, 43, "abort_q");
      wait_idle("abort");
      start(32'hFFFFFFFF, 32'd16, 1'b1, 1'b1, 32'd15, 0, "abort_r");
      wait_idle("abort_r");

      // Reset in the fifth RUN cycle.
      dif.rm = 1'b0;
      load_only(32'd100, 32'd7, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("midrun_reset_busy", {31'd0, dif.busy}, 32'd0);
      check("midrun_reset_out_q", dif.out, 32'd0);
      dif.rm = 1'b1;
      #1;
      check("midrun_reset_out_r", dif.out, 32'd0);
      dif.rm = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      div_pair(32'd0, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd0, "zero_zero");

      repeat (3) @(posedge clk);
      check("scoreboard_empty", sb_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
